// File: rtl/wb_stream_capture_if.sv
// Wishbone classic slave bus bundle for wb_stream_capture.
// Signal names keep the slave-side suffixes: _i are driven by the bus master,
// _o are driven by the capture block.
//   master modport : drives cyc/stb/we/adr/dat_i/sel, receives dat_o/ack/err/rty
//   slave  modport : the mirror image, used by wb_stream_capture
interface wb_stream_capture_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [21:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_stream_capture.sv
// AXI4-Stream sample capture buffer with a Wishbone classic register/buffer port.
// Ports:
//   wb_clk_i       sole clock (rising edge)
//   wb_rst_i       synchronous active-high reset
//   wb             Wishbone slave (wb_stream_capture_if.slave)
//   s_axis_tdata   32-bit sample input
//   s_axis_tvalid  sample valid
//   s_axis_tready  high only while capturing
// Map: adr[21]=0 registers (ID, CTRL, STATUS, LENGTH at 0x0..0xC),
//      adr[21]=1 read-only buffer window, word index adr[DEPTH_LOG2+1:2].
module wb_stream_capture #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] IDENT      = 32'h57534350
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_stream_capture_if.slave   wb,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t          state_q;
    logic            tready_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   eff_len_q;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     reg_dat_q;
    logic            buf_sel_q;
    logic [31:0]     ram_rd_q;
    logic [31:0]     mem [DEPTH];

    logic            new_acc;
    logic            is_buf;
    logic            reg_ok;
    logic            ack_d;
    logic            err_d;
    logic            buf_rd;
    logic            wr_ctrl;
    logic            wr_len;
    logic            arm;
    logic            abort;
    logic            beat;
    logic [CW-1:0]   count_inc;
    logic [CW-1:0]   len_eff_d;
    logic [31:0]     status;
    logic [31:0]     reg_dat_d;

    // Access decode, termination select and register read mux.
    always_comb begin
        new_acc   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
        is_buf    = wb.wb_adr_i[21];
        reg_ok    = (wb.wb_adr_i[20:4] == 17'd0);
        // Buffer window is read-only; register space must sit in the first 16 bytes.
        err_d     = new_acc & (is_buf ? wb.wb_we_i : ~reg_ok);
        ack_d     = new_acc & ~err_d;
        buf_rd    = ack_d & is_buf & ~wb.wb_we_i;
        wr_ctrl   = ack_d & ~is_buf & wb.wb_we_i & (wb.wb_adr_i[3:2] == 2'd1);
        wr_len    = ack_d & ~is_buf & wb.wb_we_i & (wb.wb_adr_i[3:2] == 2'd3);
        // ABORT wins over ARM when both bits are written together.
        arm       = wr_ctrl & wb.wb_dat_i[0] & ~wb.wb_dat_i[1];
        abort     = wr_ctrl & wb.wb_dat_i[1];
        beat      = s_axis_tvalid & tready_q;
        count_inc = count_q + CW'(1);
        len_eff_d = ((len_q == '0) || (len_q > FULL_LEN)) ? FULL_LEN : len_q;
        status    = {16'(count_q), 14'd0, (state_q == ST_DONE), (state_q == ST_CAPTURE)};
        reg_dat_d = 32'd0;
        if (ack_d && !is_buf && !wb.wb_we_i) begin
            unique case (wb.wb_adr_i[3:2])
                2'd0:    reg_dat_d = IDENT;
                2'd2:    reg_dat_d = status;
                2'd3:    reg_dat_d = 32'(len_q);
                default: reg_dat_d = 32'd0;
            endcase
        end
    end

    // Capture FSM, registers and bus termination.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            tready_q  <= 1'b0;
            count_q   <= '0;
            len_q     <= '0;
            eff_len_q <= FULL_LEN;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            reg_dat_q <= 32'd0;
            buf_sel_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            reg_dat_q <= reg_dat_d;
            buf_sel_q <= buf_rd;
            if (wr_len) begin
                len_q <= wb.wb_dat_i[CW-1:0];
            end
            // A beat already offered against a high tready is always taken,
            // even in the cycle an abort is written.
            if (beat) begin
                count_q <= count_inc;
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_q   <= ST_CAPTURE;
                        tready_q  <= 1'b1;
                        count_q   <= '0;
                        eff_len_q <= len_eff_d;
                    end
                end
                ST_CAPTURE: begin
                    if (beat && (count_inc == eff_len_q)) begin
                        state_q  <= ST_DONE;
                        tready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tready_q <= 1'b0;
                end
            endcase
            if (abort) begin
                state_q  <= ST_IDLE;
                tready_q <= 1'b0;
            end
        end
    end

    // Capture RAM: write port from the stream, synchronous read port from the bus.
    always_ff @(posedge wb_clk_i) begin
        if (beat && !wb_rst_i) begin
            mem[count_q[AW-1:0]] <= s_axis_tdata;
        end
        if (buf_rd) begin
            ram_rd_q <= mem[wb.wb_adr_i[AW+1:2]];
        end
    end

    assign wb.wb_dat_o   = buf_sel_q ? ram_rd_q : reg_dat_q;
    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_err_o   = err_q;
    assign wb.wb_rty_o   = 1'b0;
    assign s_axis_tready = tready_q;

    // Byte selects, low address bits and unused data bits have no function.
    logic unused_ok;
    assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

endmodule

// File: tb/tb_wb_stream_capture.sv
module tb_wb_stream_capture;

    localparam logic [21:0] A_ID   = 22'h000000;
    localparam logic [21:0] A_CTRL = 22'h000004;
    localparam logic [21:0] A_STAT = 22'h000008;
    localparam logic [21:0] A_LEN  = 22'h00000C;
    localparam logic [21:0] A_BUF  = 22'h200000;
    localparam logic [31:0] ID_VAL = 32'h57534350;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    wb_stream_capture_if wb_if();

    wb_stream_capture #(.DEPTH_LOG2(10), .IDENT(32'h57534350)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb            (wb_if),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    // Monitor: every termination pops one expectation from the scoreboard.
    always @(negedge clk) begin
        if (wb_if.wb_ack_o === 1'b1 || wb_if.wb_err_o === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_term: ack=%b err=%b dat=%h with nothing pending",
                         wb_if.wb_ack_o, wb_if.wb_err_o, wb_if.wb_dat_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (wb_if.wb_ack_o !== !e.err || wb_if.wb_err_o !== e.err || wb_if.wb_dat_o !== e.dat)
                    $display("FAIL %s: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                             e.name, wb_if.wb_ack_o, wb_if.wb_err_o, wb_if.wb_dat_o,
                             !e.err, e.err, e.dat);
                else passed++;
            end
        end
    end

    // One strobe, expectation queued; termination must be consumed within one cycle.
    task automatic wb_xfer(input logic we, input logic [21:0] adr, input logic [31:0] wdat,
                           input bit exp_err, input logic [31:0] exp_dat, input string nm);
        exp_t e;
        @(posedge clk); #1;
        wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = we;
        wb_if.wb_adr_i = adr;  wb_if.wb_dat_i = wdat; wb_if.wb_sel_i = 4'hF;
        e.err = exp_err; e.dat = exp_dat; e.name = nm;
        sb.push_back(e);
        @(posedge clk); #1;
        wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            chk({"latency_", nm}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [21:0] adr, input logic [31:0] d, input string nm);
        wb_xfer(1'b1, adr, d, 1'b0, 32'd0, nm);
    endtask

    task automatic rd(input logic [21:0] adr, input logic [31:0] exp, input string nm);
        wb_xfer(1'b0, adr, 32'd0, 1'b0, exp, nm);
    endtask

    // Offer one beat; returns whether it was accepted within max_wait cycles.
    task automatic send_beat(input logic [31:0] d, input int gap, input int max_wait, output bit acc);
        acc = 1'b0; tdata = d; tvalid = 1'b1;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            if (tready === 1'b1) begin
                @(posedge clk); #1;
                acc = 1'b1;
            end
        end
        tvalid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        rst = 1'b1; tdata = 32'd0; tvalid = 1'b0;
        wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
        wb_if.wb_adr_i = 22'd0; wb_if.wb_dat_i = 32'd0; wb_if.wb_sel_i = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_ack",    32'(wb_if.wb_ack_o), 32'd0);
        chk("rst_err",    32'(wb_if.wb_err_o), 32'd0);
        chk("rst_dat",    wb_if.wb_dat_o, 32'd0);
        chk("rty_const",  32'(wb_if.wb_rty_o), 32'd0);

        // Register reads and decode error
        rd(A_ID, ID_VAL, "read_id");
        wb_xfer(1'b0, 22'h000010, 32'd0, 1'b1, 32'd0, "read_0x10_err");
        rd(A_STAT, 32'h0000_0000, "status_reset");
        rd(A_LEN,  32'h0000_0000, "length_reset");
        rd(A_CTRL, 32'h0000_0000, "ctrl_reads_zero");

        // LENGTH=4: five beats with gaps, only four taken
        wr(A_LEN, 32'd4, "wr_len4");
        wr(A_CTRL, 32'h1, "arm_len4");
        rd(A_STAT, 32'h0000_0001, "status_busy");
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h11 * (i + 1), 0, 20, acc);
            if (acc) n_acc++;
            if (i < 3) begin
                repeat (i + 1) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("tready_low_after_4th", 32'(tready), 32'd0);
        chk("len4_accepted", 32'(n_acc), 32'd4);
        send_beat(32'h55, 0, 4, acc);
        chk("fifth_beat_refused", 32'(acc), 32'd0);
        rd(A_STAT, 32'h0004_0002, "status_len4_done");
        for (int i = 0; i < 4; i++)
            rd(A_BUF | 22'(i << 2), 32'h11 * (i + 1), $sformatf("buf_word%0d", i));

        // Abort mid-capture, re-arm, ARM ignored while capturing
        wr(A_LEN, 32'd8, "wr_len8");
        wr(A_CTRL, 32'h1, "arm_len8");
        for (int i = 0; i < 3; i++) send_beat(32'hB0 + 32'(i), 1, 20, acc);
        wr(A_CTRL, 32'h3, "abort_with_arm");
        rd(A_STAT, 32'h0003_0000, "status_after_abort");
        wr(A_CTRL, 32'h1, "rearm");
        rd(A_STAT, 32'h0000_0001, "status_rearm");
        send_beat(32'hA0, 0, 20, acc);
        send_beat(32'hA1, 2, 20, acc);
        wr(A_CTRL, 32'h1, "arm_in_capture");
        send_beat(32'hA2, 0, 20, acc);
        rd(A_STAT, 32'h0003_0001, "status_arm_ignored");
        wr(A_CTRL, 32'h2, "abort_only");
        rd(A_STAT, 32'h0003_0000, "status_idle_count3");

        // Illegal and ignored writes
        wb_xfer(1'b1, A_BUF, 32'hDEADBEEF, 1'b1, 32'd0, "write_buf_err");
        rd(A_BUF, 32'hA0, "buf_word0_unchanged");
        wr(A_STAT, 32'hFFFFFFFF, "write_status_ack");
        rd(A_STAT, 32'h0003_0000, "status_unchanged");
        wr(A_ID, 32'h0, "write_id_ack");
        rd(A_ID, ID_VAL, "id_unchanged");
        wr(A_LEN, 32'hFFFFFFFF, "wr_len_all_ones");
        rd(A_LEN, 32'h0000_07FF, "len_masked");

        // LENGTH=0 means full depth: 1024 continuous beats
        wr(A_LEN, 32'd0, "wr_len0");
        wr(A_CTRL, 32'h1, "arm_full");
        n_acc = 0;
        for (int i = 0; i < 1024; i++) begin
            send_beat(32'(i), 0, 20, acc);
            if (acc) n_acc++;
        end
        chk("full_accepted", 32'(n_acc), 32'd1024);
        rd(A_STAT, 32'h0400_0002, "status_full_done");
        rd(A_BUF | 22'h000FFC, 32'd1023, "buf_word1023");
        rd(A_BUF, 32'd0, "buf_word0_full");

        // Reset during capture with a strobe pending
        wr(A_LEN, 32'd16, "wr_len16");
        wr(A_CTRL, 32'h1, "arm_before_rst");
        tdata = 32'h77; tvalid = 1'b1;
        @(negedge clk);
        chk("tready_before_rst", 32'(tready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0; wb_if.wb_adr_i = A_ID;
        @(posedge clk); #1;
        rst = 1'b0;
        wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
        @(negedge clk);
        chk("rst_cap_tready", 32'(tready), 32'd0);
        chk("rst_cancel_ack", 32'({wb_if.wb_ack_o, wb_if.wb_err_o}), 32'd0);
        tvalid = 1'b0;
        rd(A_STAT, 32'h0000_0000, "status_after_rst");
        rd(A_LEN,  32'h0000_0000, "length_after_rst");

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
